gamepad_pmod_transmitter: RTL and testbench
===========================================

GAMEPAD_PMOD_TRANSMITTER -- requirements
Module: gamepad_pmod_transmitter

Interface
REQ-001 Parameter BIT_WIDTH, default 12: frame length in bits (12 = one controller, 24 = two controllers).
REQ-002 Parameter HALF_PERIOD, default 4: clk cycles per pmod_clk half period; legal range >= 2.
REQ-003 Parameter LATCH_CYCLES, default 4: clk cycles pmod_latch is held high; legal range >= 3.
REQ-004 Parameter GAP_CYCLES, default 8: idle clk cycles after latch falls before the frame ends; legal range >= 1.
REQ-005 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 enable  input  1  request a frame; sampled only in IDLE.
REQ-008 buttons  input  BIT_WIDTH  button word; MSB sent first; 12-bit order {b,y,select,start,up,down,left,right,a,x,l,r}; 1 = pressed.
REQ-009 pmod_data  output  1  serial data, registered.
REQ-010 pmod_clk  output  1  serial clock, registered; receiver samples on its rising edge.
REQ-011 pmod_latch  output  1  frame latch, registered; receiver transfers the word on its rising edge.
REQ-012 busy  output  1  high from frame start through the last GAP cycle.
REQ-013 frame_done  output  1  one-cycle pulse on the last GAP cycle.

Function
REQ-014 States: IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP; all outputs are registered.
REQ-015 IDLE: pmod_clk=0, pmod_latch=0, busy=0. If enable=1 at edge t0, then at t0+1: buttons snapshot into the shift register, pmod_data=buttons[BIT_WIDTH-1], busy=1, state SHIFT_LO.
REQ-016 SHIFT_LO: pmod_clk=0 for HALF_PERIOD cycles, then SHIFT_HI.
REQ-017 SHIFT_HI: pmod_clk=1 for HALF_PERIOD cycles, with pmod_data unchanged.
REQ-018 SHIFT_HI end, bits sent < BIT_WIDTH: shift left, pmod_data = next bit, pmod_clk=0, state SHIFT_LO.
REQ-019 Data changes only on pmod_clk falling transitions.
REQ-020 Rising edge k (k=0..BIT_WIDTH-1) of pmod_clk occurs at t0+1+HALF_PERIOD*(2k+1).
REQ-021 SHIFT_HI end after bit BIT_WIDTH-1: pmod_clk=0, pmod_data=0, pmod_latch=1 at t0+1+2*BIT_WIDTH*HALF_PERIOD, state LATCH.
REQ-022 LATCH: pmod_latch high for exactly LATCH_CYCLES cycles, then pmod_latch=0, state GAP.
REQ-023 GAP: lasts GAP_CYCLES cycles; frame_done=1 on the last GAP cycle only; then IDLE with busy=0.
REQ-024 Frame period is 2*BIT_WIDTH*HALF_PERIOD+LATCH_CYCLES+GAP_CYCLES+1 cycles (109 at defaults); enable held high gives back-to-back frames at exactly this period.
REQ-025 Changes on buttons or enable during a frame have no effect; a started frame always completes.
REQ-026 Exactly BIT_WIDTH pmod_clk rising edges and one pmod_latch rising edge per frame; pmod_clk and pmod_latch are never high together.
REQ-027 Counters: half-period counter is sized for max(HALF_PERIOD, LATCH_CYCLES, GAP_CYCLES); bit counter is clog2(BIT_WIDTH+1) bits; no wrap within legal parameters.

Reset
REQ-028 rst_n=0 immediately forces state IDLE and pmod_data=0, pmod_clk=0, pmod_latch=0, busy=0, frame_done=0, and clears all counters and the shift register.
REQ-029 Reset mid-frame emits no latch, so a connected receiver keeps its previous word.
REQ-030 The first frame may start on the first edge after rst_n deasserts with enable=1.

Verification (loopback into gamepad_pmod_single, defaults)
REQ-031 buttons=12'hA5C, enable pulsed at t0 -> data at the 12 rising edges = 1,0,1,0,0,1,0,1,1,1,0,0; decoder reports b=1,y=0,select=1,start=0,up=0,down=1,left=0,right=1,a=1,x=1,l=0,r=0; is_present=1.
REQ-032 Timing for the same frame -> busy=1 at t0+1, first pmod_clk rise at t0+5, pmod_latch high t0+97..t0+100, frame_done only at t0+108, busy=0 at t0+109.
REQ-033 enable held high for three frames -> latch rises 109 cycles apart; frame_done count = 3.
REQ-034 Frame started with 12'h001; buttons changed to 12'hFFE at t0+30 -> decoder r=1 and all other buttons 0.
REQ-035 Frame 12'h800 completed; next frame 12'h010 reset (rst_n=0) at t0+40 -> all outputs 0 asynchronously; decoder still shows b=1 only; next full frame after release is decoded correctly.
REQ-036 buttons=12'hFFF -> decoder is_present=0 and all buttons 0.

Source files
------------

// File: rtl/gamepad_pmod_transmitter.sv
// gamepad_pmod_transmitter
// Serialises a button word onto a three-wire PMOD gamepad link. A frame is
// BIT_WIDTH data bits, sent MSB first with a clock the receiver samples on its
// rising edge. A latch pulse follows, on whose rising edge the receiver takes
// the word. A short idle gap then closes the frame.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   enable     frame request, only looked at while idle
//   buttons    button word, snapshotted when a frame starts
//   pmod_data  serial data, changes only while pmod_clk is low
//   pmod_clk   serial clock, HALF_PERIOD clk cycles low then high per bit
//   pmod_latch high for LATCH_CYCLES cycles after the last bit
//   busy       high for the whole frame, including the gap
//   frame_done one-cycle pulse on the last gap cycle
module gamepad_pmod_transmitter #(
  parameter int BIT_WIDTH    = 12,
  parameter int HALF_PERIOD  = 4,
  parameter int LATCH_CYCLES = 4,
  parameter int GAP_CYCLES   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [BIT_WIDTH-1:0] buttons,
  output logic                 pmod_data,
  output logic                 pmod_clk,
  output logic                 pmod_latch,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int MAX_A   = (HALF_PERIOD > LATCH_CYCLES) ? HALF_PERIOD : LATCH_CYCLES;
  localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int BCW     = $clog2(BIT_WIDTH + 1);
  // The shift register holds only the bits not yet on pmod_data.
  localparam int RW      = BIT_WIDTH - 1;

  localparam logic [CW-1:0]  ONE        = CW'(1);
  localparam logic [CW-1:0]  HALF_LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0]  LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(BIT_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH,
    GAP
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [BCW-1:0] bit_cnt;
  logic [RW-1:0]  shreg;
  logic [CW-1:0]  cnt_next;

  assign cnt_next = cnt + ONE;

  // Frame sequencer. Each timed state counts cnt from 0 up to its last cycle.
  // Every output is assigned here, so all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      pmod_data  <= 1'b0;
      pmod_clk   <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          pmod_clk   <= 1'b0;
          pmod_latch <= 1'b0;
          busy       <= 1'b0;
          if (enable) begin
            pmod_data <= buttons[BIT_WIDTH-1];
            shreg     <= buttons[RW-1:0];
            busy      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            state     <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            pmod_clk <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            cnt <= cnt_next;
          end
        end

        SHIFT_HI: begin
          if (cnt == HALF_LAST) begin
            cnt      <= '0;
            pmod_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // Data is parked low so the latch never sees a stale bit.
              pmod_data  <= 1'b0;
              pmod_latch <= 1'b1;
              state      <= LATCH;
            end else begin
              pmod_data <= shreg[RW-1];
              shreg     <= RW'({shreg, 1'b0});
              bit_cnt   <= bit_cnt + BCW'(1);
              state     <= SHIFT_LO;
            end
          end else begin
            cnt <= cnt_next;
          end
        end

        LATCH: begin
          if (cnt == LATCH_LAST) begin
            cnt        <= '0;
            pmod_latch <= 1'b0;
            // With a one-cycle gap the first gap cycle is also the last.
            frame_done <= (GAP_CYCLES == 1);
            state      <= GAP;
          end else begin
            cnt <= cnt_next;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt        <= cnt_next;
            frame_done <= (cnt_next == GAP_LAST);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// tb_gamepad_pmod_transmitter
// Scoreboard bench for gamepad_pmod_transmitter at default parameters.
// The stimulus process queues one expected frame (word and start cycle) per
// frame it launches. The monitor predicts every output on every cycle from
// the frame timing rules. It also rebuilds the word from pmod_clk rising
// edges and compares that word on each pmod_latch rising edge.
module tb_gamepad_pmod_transmitter;

  localparam int BW = 12;
  localparam int HP = 4;
  localparam int LC = 4;
  localparam int GC = 8;
  localparam int SHIFT_END = 2 * BW * HP;
  localparam int LATCH_END = SHIFT_END + LC;
  localparam int DONE_REL  = LATCH_END + GC;
  localparam int PERIOD    = DONE_REL + 1;

  typedef struct packed {
    logic [BW-1:0] word;
    int            t0;
  } frame_t;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [BW-1:0] buttons;
  logic          pmod_data;
  logic          pmod_clk;
  logic          pmod_latch;
  logic          busy;
  logic          frame_done;

  frame_t        exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            fail_prints = 0;
  int            cyc = 0;
  int            done_count = 0;
  int            latch_count = 0;
  int            exp_done = 0;
  logic [BW-1:0] acc = '0;
  logic [BW-1:0] last_word = '0;
  int            nbits = 0;
  logic          prev_clk = 1'b0;
  logic          prev_latch = 1'b0;

  gamepad_pmod_transmitter #(
    .BIT_WIDTH(BW), .HALF_PERIOD(HP), .LATCH_CYCLES(LC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .buttons(buttons),
    .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter. It is read only on falling edges. A frame whose enable is
  // applied at the falling edge showing cyc==C has t0=C.
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
      end
    end
  endtask

  // Output vector {data, clk, latch, busy, done} expected rel cycles after t0.
  function automatic logic [4:0] expect_at(input frame_t f, input int c);
    int   rel;
    int   k;
    logic d, ck, l, b, dn;
    rel = c - f.t0;
    d  = 1'b0;
    ck = 1'b0;
    if (rel >= 1 && rel <= SHIFT_END) begin
      k  = (rel - 1) / (2 * HP);
      ck = ((rel - 1) % (2 * HP)) >= HP;
      d  = f.word[BW-1-k];
    end
    l  = (rel > SHIFT_END) && (rel <= LATCH_END);
    b  = (rel >= 1) && (rel <= DONE_REL);
    dn = (rel == DONE_REL);
    return {d, ck, l, b, dn};
  endfunction

  // Monitor: compares the whole output vector each cycle and checks the
  // received word on each latch. The front frame is retired after its
  // frame_done cycle. With nothing queued, all outputs must be quiet.
  always @(negedge clk) begin
    logic [4:0] got;
    logic [4:0] expv;
    if (!rst_n) begin
      nbits      = 0;
      acc        = '0;
      prev_clk   = 1'b0;
      prev_latch = 1'b0;
    end else begin
      got  = {pmod_data, pmod_clk, pmod_latch, busy, frame_done};
      expv = (exp_q.size() > 0) ? expect_at(exp_q[0], cyc) : 5'b0;
      check_output($sformatf("wave@%0d", cyc), {27'b0, got}, {27'b0, expv});
      if (pmod_clk && !prev_clk) begin
        acc = {acc[BW-2:0], pmod_data};
        nbits++;
      end
      if (pmod_latch && !prev_latch) begin
        latch_count++;
        if (exp_q.size() > 0) begin
          check_output("word", {20'b0, acc}, {20'b0, exp_q[0].word});
          check_output("bits_per_frame", nbits, BW);
        end else begin
          check_output("unexpected_latch", 1, 0);
        end
        last_word = acc;
        nbits     = 0;
      end
      if (frame_done) done_count++;
      if (exp_q.size() > 0 && (cyc - exp_q[0].t0) >= DONE_REL) void'(exp_q.pop_front());
      prev_clk   = pmod_clk;
      prev_latch = pmod_latch;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_output("idle_timeout", 1, 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Launches one frame from idle and returns its t0. Buttons are scrambled
  // straight after the sampling edge, which must not affect the frame.
  task automatic apply_stimulus(input logic [BW-1:0] w, output int t0);
    wait_idle();
    buttons = w;
    enable  = 1'b1;
    t0      = cyc;
    exp_q.push_back('{word: w, t0: t0});
    exp_done++;
    @(negedge clk);
    enable  = 1'b0;
    buttons = BW'($urandom);
  endtask

  initial begin
    int            t0;
    int            d0;
    logic [BW-1:0] w;

    rst_n   = 1'b0;
    enable  = 1'b0;
    buttons = '0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", {27'b0, pmod_data, pmod_clk, pmod_latch, busy, frame_done}, 0);

    // A frame starting on the first edge after reset release.
    rst_n   = 1'b1;
    enable  = 1'b1;
    buttons = 12'hA5C;
    exp_q.push_back('{word: 12'hA5C, t0: cyc});
    exp_done++;
    @(negedge clk);
    enable  = 1'b0;
    buttons = '0;

    // Buttons change mid-frame: the snapshot must win.
    apply_stimulus(12'h001, t0);
    wait_until(t0 + 30);
    buttons = 12'hFFE;

    // Enable held high: three back-to-back frames, one period apart.
    wait_idle();
    d0      = done_count;
    w       = BW'($urandom);
    buttons = w;
    enable  = 1'b1;
    t0      = cyc;
    exp_q.push_back('{word: w, t0: t0});
    exp_done++;
    for (int f = 1; f < 3; f++) begin
      wait_until(t0 + 30);
      w       = BW'($urandom);
      buttons = w;
      exp_q.push_back('{word: w, t0: t0 + PERIOD});
      exp_done++;
      t0 += PERIOD;
    end
    wait_until(t0 + 5);
    enable = 1'b0;
    wait_idle();
    check_output("held_enable_frames", done_count - d0, 3);

    // A completed frame, then a reset in the middle of the next one.
    apply_stimulus(12'h800, t0);
    apply_stimulus(12'h010, t0);
    wait_until(t0 + 40);
    rst_n = 1'b0;
    exp_q.delete();
    exp_done--;
    #1;
    check_output("async_reset_outputs", {27'b0, pmod_data, pmod_clk, pmod_latch, busy, frame_done}, 0);
    check_output("word_kept_after_abort", {20'b0, last_word}, 32'h800);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(12'h010, t0);

    // All-ones and all-zeros words.
    apply_stimulus(12'hFFF, t0);
    apply_stimulus(12'h000, t0);

    // Random frames with buttons and enable churning during the frame.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      apply_stimulus(BW'($urandom), t0);
      while (cyc < t0 + SHIFT_END + 4) begin
        buttons = BW'($urandom);
        enable  = 1'($urandom);
        @(negedge clk);
      end
      enable = 1'b0;
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check_output("frame_done_total", done_count, exp_done);
    check_output("latch_total", latch_count, exp_done);
    check_output("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
